// File: rtl/rcv_buf8b.sv
// Receive buffer: DEPTH x 8-bit first-word fall-through FIFO with occupancy flags.
// Define RCV_BUF8B_OVF_EN to add the sticky OVF (dropped-write) output.
module rcv_buf8b #(
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic [7:0]                 I,
    input  logic                       STB,
    output logic [7:0]                 O,
    output logic                       VO,
    input  logic                       RDY,
    output logic [$clog2(DEPTH):0]     CNT,
    output logic                       FULL,
    output logic                       EMPTY
`ifdef RCV_BUF8B_OVF_EN
    ,
    output logic                       OVF
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a byte moves out on a rising edge with VO=1 and RDY=1; a byte
    // moves in with STB=1 when not full, or when full and a read frees a slot
    // on the same edge. STB has no backpressure, so refused writes are lost.
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full;
    logic          empty;
    logic          do_rd;
    logic          do_wr;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign do_rd = ~empty & RDY;
    assign do_wr = STB & (~full | do_rd);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = I;
            // Power-of-two depth lets the pointer wrap by natural overflow.
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is left unreset; occupancy alone decides what is visible.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign O     = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign VO    = ~empty;
    assign CNT   = cnt_q;
    assign FULL  = full;
    assign EMPTY = empty;

`ifdef RCV_BUF8B_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q | (STB & full & ~do_rd);
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

endmodule

// File: doc/rcv_buf8b.md
RCV_BUF8B -- requirements
Module: rcv_buf8b

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of 8-bit entries; legal values are 2, 4 and 8 (power of two).
REQ-002 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 CLR  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 I  input  8  SHALL carry the received bus byte.
REQ-005 STB  input  1  SHALL qualify I; a high level is a write request.
REQ-006 O  output  8  SHALL present the oldest stored byte (first-word fall-through).
REQ-007 VO  output  1  SHALL be high while O holds a valid byte.
REQ-008 RDY  input  1  SHALL be the consumer's accept signal for O.
REQ-009 CNT  output  log2(DEPTH)+1  SHALL give the current occupancy.
REQ-010 FULL  output  1  SHALL be high when CNT equals DEPTH.
REQ-011 EMPTY  output  1  SHALL be high when CNT equals 0.
REQ-012 OVF  output  1  SHALL exist only when RCV_BUF8B_OVF_EN is defined (see Configuration).

Function
REQ-013 A write SHALL occur on a rising CLK edge when STB=1 and either FULL=0 or a read occurs in the same cycle.
REQ-014 A read SHALL occur on a rising CLK edge when VO=1 and RDY=1.
REQ-015 VO SHALL equal the inverse of EMPTY, driven combinationally from the registered count.
REQ-016 A byte written at edge N SHALL appear on O with VO=1 after edge N when the buffer was empty (1-cycle latency).
REQ-017 O SHALL be 8'h00 whenever EMPTY=1.
REQ-018 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 A simultaneous read and write SHALL leave CNT unchanged and advance both pointers.
REQ-020 A simultaneous read and write when FULL=1 SHALL accept the new byte and leave CNT=DEPTH.
REQ-021 A write with STB=1 while FULL=1 and no read SHALL be dropped; storage, pointers and CNT SHALL be unchanged.
REQ-022 A read with RDY=1 while EMPTY=1 SHALL have no effect, and CNT SHALL never underflow.
REQ-023 Bytes SHALL leave in exactly the order accepted.

Reset
REQ-024 While CLR=1, pointers and CNT SHALL be 0, EMPTY SHALL be 1, FULL and VO SHALL be 0, and O SHALL be 8'h00, regardless of CLK.
REQ-025 Assertion of CLR mid-operation SHALL discard all stored bytes immediately.
REQ-026 The first write SHALL be accepted at the first rising edge after CLR deasserts.
REQ-027 Storage array contents need not be reset.

Configuration
REQ-028 With RCV_BUF8B_OVF_EN defined, OVF SHALL be a sticky register set on any dropped write (REQ-021) and cleared only by CLR.
REQ-029 With RCV_BUF8B_OVF_EN undefined, the OVF port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then STB=1 with I=8'hA5 for 1 cycle -> after the next edge O=8'hA5, VO=1, CNT=1.
REQ-031 Write 8'h01..8'h04 with RDY=0 (DEPTH=4) -> FULL=1, CNT=4; then RDY=1 -> O sequence 01,02,03,04; then EMPTY=1, O=8'h00.
REQ-032 FULL, then STB=1 with I=8'hFF and RDY=0 -> CNT stays 4 and 8'hFF is never output; with the macro defined, OVF=1 until CLR.
REQ-033 FULL, then STB=1 with I=8'h55 and RDY=1 for 1 cycle -> CNT stays 4 and 8'h55 is output 4th after the remaining bytes.
REQ-034 Write 10 bytes with STB=1 and RDY=1 continuously -> CNT stays 1 after the first edge, bytes are output in order, and pointers wrap without loss.
REQ-035 CLR pulse asynchronous to CLK while CNT=3 -> CNT=0, VO=0, O=8'h00 before the next CLK edge.
